// File: rtl/mips_cpu_alu_arbiter.sv
// mips_cpu_alu_arbiter
// Shares one registered ALU between the execute-stage controller (requester 0)
// and the branch/address helper (requester 1). Each accepted operation drives
// the ALU for a single cycle. The result comes back on a shared response
// channel that carries a one-hot valid per requester.
module mips_cpu_alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_sa,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_sa,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_sa,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    // Opcode 15 is illegal for requesters and doubles as the ALU no-op.
    localparam logic [3:0] OP_NOP = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // last_grant = 1 means requester 1 was served most recently
    logic        last_grant;

    // Operation latched on accept
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  sa_q;
    logic        owner_q;
    logic        err_q;

    // Arbitration results
    logic        arb_open;
    logic [1:0]  grant;
    logic        accept;
    logic        sel_owner;
    logic [3:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [4:0]  sel_sa;
    logic        sel_err;

    // Grant selection. A new grant is only possible while idle, or while a
    // response is being consumed this cycle. Ties go to the requester not
    // served last when round-robin is on, otherwise to requester 0.
    always_comb begin
        arb_open  = (state == IDLE) || ((state == RESP) && rsp_ready[owner_q]);
        grant     = 2'b00;
        if (!reset && arb_open) begin
            unique case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11: begin
                    if (RR_EN && !last_grant) begin
                        grant = 2'b10;
                    end else begin
                        grant = 2'b01;
                    end
                end
                default: grant = 2'b00;
            endcase
        end
        accept    = |grant;
        sel_owner = grant[1];
        sel_op    = sel_owner ? req1_op : req0_op;
        sel_a     = sel_owner ? req1_a  : req0_a;
        sel_b     = sel_owner ? req1_b  : req0_b;
        sel_sa    = sel_owner ? req1_sa : req0_sa;
        sel_err   = (sel_op == OP_NOP);
        req_ready = grant;
    end

    // Next-state decision for the IDLE -> EXEC -> RESP sequence. Illegal
    // opcodes skip EXEC so the ALU is never touched for them.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = sel_err ? RESP : EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    if (accept) begin
                        state_next = sel_err ? RESP : EXEC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register, arbitration history, and operation latches that are
    // loaded only on the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_q       <= OP_NOP;
            a_q        <= '0;
            b_q        <= '0;
            sa_q       <= '0;
            owner_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                last_grant <= sel_owner;
                op_q       <= sel_op;
                a_q        <= sel_a;
                b_q        <= sel_b;
                sa_q       <= sel_sa;
                owner_q    <= sel_owner;
                err_q      <= sel_err;
            end
        end
    end

    // ALU drive during EXEC only and the response channel during RESP only.
    // Everywhere else the ALU sees a no-op and the response reads as zero.
    always_comb begin
        alu_op     = OP_NOP;
        alu_a      = '0;
        alu_b      = '0;
        alu_sa     = '0;
        rsp_valid  = 2'b00;
        rsp_result = '0;
        rsp_zero   = 1'b0;
        rsp_err    = 1'b0;
        unique case (state)
            EXEC: begin
                alu_op = op_q;
                alu_a  = a_q;
                alu_b  = b_q;
                alu_sa = sa_q;
            end
            RESP: begin
                rsp_valid  = owner_q ? 2'b10 : 2'b01;
                rsp_result = err_q ? 32'h0 : alu_result;
                rsp_zero   = err_q ? 1'b0  : alu_zero;
                rsp_err    = err_q;
            end
            default: begin
                alu_op = OP_NOP;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_cpu_alu_arbiter.sv
// Testbench for mips_cpu_alu_arbiter: directed cases followed by random
// traffic, with a queue-based scoreboard and a behavioural ALU.
module tb_mips_cpu_alu_arbiter;

    localparam bit RR = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_sa, req1_sa;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_sa;
    logic [31:0] alu_result = 32'h0;
    logic        alu_zero = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit running = 1'b0;
    bit last_g = 1'b1;

    typedef struct {
        logic [1:0]  owner_oh;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sa;
        logic [31:0] result;
        logic        zero;
        logic        err;
        int          due;
    } exp_t;

    exp_t exp_q[$];

    mips_cpu_alu_arbiter #(.RR_EN(RR)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sa    (req0_sa),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sa    (req1_sa),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sa     (alu_sa),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    always #5 clk = ~clk;

    // MIPS-style ALU function used by both the ALU model and the scoreboard
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sa);
        logic [31:0] r;
        case (op)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd3:    r = a - b;
            4'd4:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5:    r = ~(a | b);
            4'd6:    r = a ^ b;
            4'd7:    r = b << sa;
            4'd8:    r = $signed(b) >>> sa;
            4'd9:    r = b >> sa;
            4'd10:   r = b << a[4:0];
            4'd11:   r = $signed(b) >>> a[4:0];
            4'd12:   r = b >> a[4:0];
            4'd13:   r = (a < b) ? 32'd1 : 32'd0;
            4'd14:   r = {b[15:0], 16'h0000};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Registered ALU: captures on every edge where op is not the no-op
    always @(posedge clk) begin
        if (alu_op != 4'd15) begin
            alu_result <= alu_fn(alu_op, alu_a, alu_b, alu_sa);
            alu_zero   <= (alu_fn(alu_op, alu_a, alu_b, alu_sa) == 32'h0);
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor side: ALU drive, response channel and pop on consume
    task automatic checkOutput();
        logic [3:0]  e_op;
        logic [31:0] e_a, e_b;
        logic [4:0]  e_sa;
        e_op = 4'd15;
        e_a  = 32'h0;
        e_b  = 32'h0;
        e_sa = 5'd0;
        if (exp_q.size() > 0 && !exp_q[0].err && cyc == exp_q[0].due - 1) begin
            e_op = exp_q[0].op;
            e_a  = exp_q[0].a;
            e_b  = exp_q[0].b;
            e_sa = exp_q[0].sa;
        end
        cmp("alu_op", alu_op, e_op);
        cmp("alu_a", alu_a, e_a);
        cmp("alu_b", alu_b, e_b);
        cmp("alu_sa", alu_sa, e_sa);
        if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
            cmp("rsp_valid", rsp_valid, exp_q[0].owner_oh);
            cmp("rsp_result", rsp_result, exp_q[0].result);
            cmp("rsp_zero", rsp_zero, exp_q[0].zero);
            cmp("rsp_err", rsp_err, exp_q[0].err);
            if (rsp_valid == 2'b00 || (rsp_ready & exp_q[0].owner_oh) != 2'b00) begin
                void'(exp_q.pop_front());
            end
        end else begin
            cmp("rsp_valid_quiet", rsp_valid, 32'h0);
        end
    endtask

    // Reference arbitration: a grant is possible only with nothing outstanding
    task automatic checkArbiter();
        logic [1:0] e_ready;
        exp_t       e;
        e_ready = 2'b00;
        if (exp_q.size() == 0) begin
            case (req_valid)
                2'b01:   e_ready = 2'b01;
                2'b10:   e_ready = 2'b10;
                2'b11:   e_ready = (RR && !last_g) ? 2'b10 : 2'b01;
                default: e_ready = 2'b00;
            endcase
        end
        cmp("req_ready", req_ready, e_ready);
        if (e_ready != 2'b00) begin
            e.owner_oh = e_ready;
            e.op       = e_ready[1] ? req1_op : req0_op;
            e.a        = e_ready[1] ? req1_a  : req0_a;
            e.b        = e_ready[1] ? req1_b  : req0_b;
            e.sa       = e_ready[1] ? req1_sa : req0_sa;
            e.err      = (e.op == 4'd15);
            e.result   = e.err ? 32'h0 : alu_fn(e.op, e.a, e.b, e.sa);
            e.zero     = e.err ? 1'b0 : (e.result == 32'h0);
            e.due      = cyc + (e.err ? 1 : 2);
            exp_q.push_back(e);
            last_g = e_ready[1];
        end
    endtask

    // Sample everything on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (running && !reset) begin
            checkOutput();
            checkArbiter();
        end
        cyc++;
    end

    task automatic applyStimulus(input logic [1:0] v,
                                 input logic [3:0] op0, input logic [31:0] a0,
                                 input logic [31:0] b0, input logic [4:0] sa0,
                                 input logic [3:0] op1, input logic [31:0] a1,
                                 input logic [31:0] b1, input logic [4:0] sa1,
                                 input logic [1:0] rr);
        @(posedge clk);
        #1;
        req_valid = v;
        req0_op = op0; req0_a = a0; req0_b = b0; req0_sa = sa0;
        req1_op = op1; req1_a = a1; req1_b = b1; req1_sa = sa1;
        rsp_ready = rr;
    endtask

    task automatic idleCycles(input int n, input logic [1:0] rr);
        for (int i = 0; i < n; i++) begin
            applyStimulus(2'b00, 4'd0, 32'h0, 32'h0, 5'd0, 4'd0, 32'h0, 32'h0, 5'd0, rr);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req0_op = 4'd0; req0_a = 32'h0; req0_b = 32'h0; req0_sa = 5'd0;
        req1_op = 4'd0; req1_a = 32'h0; req1_b = 32'h0; req1_sa = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_req_ready", req_ready, 32'h0);
        cmp("reset_rsp_valid", rsp_valid, 32'h0);
        cmp("reset_alu_op", alu_op, 32'd15);
        reset = 1'b0;
        running = 1'b1;

        // Simple add from requester 0
        applyStimulus(2'b01, 4'd2, 32'd5, 32'd7, 5'd0, 4'd0, 32'h0, 32'h0, 5'd0, 2'b11);
        idleCycles(3, 2'b11);

        // Both requesters valid continuously: grants alternate
        for (int i = 0; i < 12; i++) begin
            applyStimulus(2'b11, 4'd3, 32'd9, 32'd9, 5'd0, 4'd3, 32'd9, 32'd9, 5'd0, 2'b11);
        end
        idleCycles(3, 2'b11);

        // Illegal opcode from requester 1
        applyStimulus(2'b10, 4'd0, 32'h0, 32'h0, 5'd0, 4'd15, 32'h1234, 32'h5678, 5'd3, 2'b11);
        idleCycles(3, 2'b11);

        // Arithmetic shift held under backpressure, with both requesters waiting
        applyStimulus(2'b01, 4'd8, 32'h0, 32'h80000000, 5'd4, 4'd0, 32'h0, 32'h0, 5'd0, 2'b00);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'b11, 4'd1, 32'hF0, 32'h0F, 5'd0, 4'd6, 32'hFF, 32'h0F, 5'd0, 2'b00);
        end
        applyStimulus(2'b00, 4'd0, 32'h0, 32'h0, 5'd0, 4'd0, 32'h0, 32'h0, 5'd0, 2'b01);
        idleCycles(4, 2'b11);

        // Reset asserted in the middle of an EXEC cycle
        applyStimulus(2'b01, 4'd2, 32'd3, 32'd4, 5'd0, 4'd0, 32'h0, 32'h0, 5'd0, 2'b11);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        cmp("exec_before_reset", alu_op, 32'd2);
        #2;
        reset = 1'b1;
        running = 1'b0;
        #1;
        cmp("rst_req_ready", req_ready, 32'h0);
        cmp("rst_rsp_valid", rsp_valid, 32'h0);
        cmp("rst_rsp_result", rsp_result, 32'h0);
        cmp("rst_rsp_zero", rsp_zero, 32'h0);
        cmp("rst_rsp_err", rsp_err, 32'h0);
        cmp("rst_alu_op", alu_op, 32'd15);
        cmp("rst_alu_a", alu_a, 32'h0);
        cmp("rst_alu_b", alu_b, 32'h0);
        cmp("rst_alu_sa", alu_sa, 32'h0);
        exp_q.delete();
        last_g = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        running = 1'b1;
        applyStimulus(2'b01, 4'd2, 32'd5, 32'd7, 5'd0, 4'd0, 32'h0, 32'h0, 5'd0, 2'b11);
        idleCycles(3, 2'b11);

        // Unsigned then signed compare with the same operands
        applyStimulus(2'b01, 4'd13, 32'd1, 32'hFFFFFFFF, 5'd0, 4'd0, 32'h0, 32'h0, 5'd0, 2'b11);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'b01, 4'd4, 32'd1, 32'hFFFFFFFF, 5'd0, 4'd0, 32'h0, 32'h0, 5'd0, 2'b11);
        end
        idleCycles(4, 2'b11);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  v;
            logic [1:0]  rr;
            logic [3:0]  o0, o1;
            logic [31:0] x0, y0, x1, y1;
            v  = 2'($urandom_range(0, 3));
            rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            o0 = 4'($urandom_range(0, 15));
            o1 = 4'($urandom_range(0, 15));
            x0 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            y0 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            x1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            y1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            applyStimulus(v, o0, x0, y0, 5'($urandom_range(0, 31)),
                          o1, x1, y1, 5'($urandom_range(0, 31)), rr);
        end
        idleCycles(8, 2'b11);

        cmp("drain", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_cpu_alu_arbiter.md
# mips_cpu_alu_arbiter

Two-requester arbiter and sequencer for the shared registered ALU (`op`, `a`, `b`, `sa` in; `result`, `zero` out; one-cycle capture latency). It sits between the execute-stage controller (requester 0) and the branch/address helper (requester 1). It grants one requester at a time and drives the ALU for exactly one cycle per operation. The result is returned on a shared response channel with a one-hot valid/ready handshake per requester.

## Interface
Parameters:
- RR_EN, default 1: 1 selects round-robin arbitration; 0 gives requester 0 fixed priority.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  2  bit i: requester i presents an operation.
- req_ready  output  2  bit i: operation of requester i is accepted this cycle. At most one bit is high.
- req0_op / req1_op  input  4  ALU opcode (0–14 legal; 15 illegal).
- req0_a / req1_a, req0_b / req1_b  input  32  operands.
- req0_sa / req1_sa  input  5  shift amount.
- rsp_valid  output  2  one-hot; response is pending for requester i.
- rsp_ready  input  2  bit i: requester i consumes its response.
- rsp_result  output  32  result; valid while any rsp_valid bit is high.
- rsp_zero  output  1  ALU zero flag for the response.
- rsp_err  output  1  request carried opcode 15.
- alu_op  output  4  ALU `op`.
- alu_a, alu_b  output  32  ALU operands.
- alu_sa  output  5  ALU `sa`.
- alu_result  input  32  ALU `result`.
- alu_zero  input  1  ALU `zero`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- Latched on accept: op, a, b, sa, owner id, err (err = op==15).
- Arbitration, evaluated in IDLE, or in RESP when the pending response is consumed (`rsp_ready[owner]`):
  - With one valid requester, that requester is granted.
  - With both valid and RR_EN=1, the requester not granted last is granted. last_grant resets to 1, so requester 0 wins the first tie.
  - With RR_EN=0, requester 0 wins every tie.
  - req_ready is the grant. It is combinational from req_valid, state and last_grant.
- IDLE:
  - On grant with err=0: latch the request and go to EXEC.
  - On grant with err=1: latch the request and go directly to RESP; the ALU is not used.
  - With no valid request: stay in IDLE.
- EXEC:
  - alu_op/a/b/sa are driven from the latches for exactly this one cycle.
  - The ALU captures on the closing edge. The FSM goes to RESP unconditionally.
- RESP:
  - `rsp_valid[owner]`=1.
  - rsp_result = alu_result, or 32'h0 if err.
  - rsp_zero = alu_zero, or 0 if err.
  - rsp_err = err.
  - When `rsp_ready[owner]`=1: a new grant, if any, latches and goes to EXEC or RESP as in IDLE; with no grant the FSM goes to IDLE.
  - Otherwise the FSM holds. All response outputs stay stable.
  - `rsp_ready` bits for the non-owner are ignored.
- Outside EXEC, alu_op=4'd15, which the ALU treats as a no-op, so alu_result holds. alu_a, alu_b and alu_sa are 0.
- No data transformation and no width changes: operands pass through bit-exact.

## Timing
- Reset (asynchronous, any state) drops any in-flight operation and forces:
  - state = IDLE, last_grant = 1;
  - req_ready = 0, rsp_valid = 0, rsp_result = 0, rsp_zero = 0, rsp_err = 0;
  - alu_op = 15, alu_a/b/sa = 0.
- Latency: request accepted at edge E0 → EXEC in cycle E0..E1 → rsp_valid high from edge E1. The response is visible in the cycle after EXEC.
- Error latency: accepted at E0 → rsp_valid from E0.
- Throughput: one operation per 2 cycles with back-to-back accept in RESP; one per 1 cycle for error requests.
- A requester may drop req_valid without it being accepted; nothing is latched.
- Operand inputs are sampled only on the accept edge.
- req_valid with an opcode change while not ready: the value present at the accept edge is used.
- Simultaneous rsp_ready consume and new request from the same requester: both handshakes complete in the same cycle.

## Test plan
- Reset then req0 with op=2, a=5, b=7 → req_ready=01 in the first cycle; rsp_valid=01 two edges later; rsp_result=12, rsp_zero=0.
- req0 and req1 both valid continuously with op=3, a=b=9, rsp_ready=11 → grants alternate 0,1,0,1; each rsp_result=0, rsp_zero=1; one response every 2 cycles. With RR_EN=0 → only requester 0 is granted.
- op=15 from req1 → rsp_valid=10 the cycle after accept; rsp_err=1, rsp_result=0; alu_op never leaves 15.
- rsp_ready held 0 for 5 cycles after op=8, b=32'h80000000, sa=4 → rsp_result stays 32'hF8000000 and req_ready stays 00 throughout.
- Assert reset during EXEC → all outputs reach reset values immediately; the next request completes normally with the correct result.
- op=13 (a=1, b=32'hFFFFFFFF) then op=4 with the same operands back-to-back → results 1 then 0; alu_op equals the request opcode only in the EXEC cycles.
